// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan capture controller: FSM state
// encodings and the default settle time / select width.
package mux_scan_pkg;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE   = 2'd0;
    localparam scan_state_t ST_SETTLE = 2'd1;
    localparam scan_state_t ST_SAMPLE = 2'd2;
    localparam scan_state_t ST_DONE   = 2'd3;

    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int SEL_W_DEF         = 3;

endpackage

// File: rtl/mux_scan_capture_settle_timer.sv
// settle_timer: loadable down-counter that raises a zero flag once the
// settle interval after a select change has elapsed.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down while enabled, parking at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps an 8:1 mux select through every channel, waits
// a settle time per channel, samples the mux output and presents the
// assembled word on a valid/ready handshake.
// Optional: define MUX_SCAN_CAPTURE_PARITY_EN to add an even-parity output.
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int SEL_W         = SEL_W_DEF,
    localparam int NUM_CH       = 1 << SEL_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    output logic [SEL_W-1:0]  Sel,
    input  logic              M_in,
    output logic [NUM_CH-1:0] Data,
    output logic              Valid,
    input  logic              Ready,
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
    output logic              Parity,
`endif
    output logic              Busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
    localparam scan_state_t AFTER_SEL =
        (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

    scan_state_t state;
    logic        timer_load;
    logic        timer_enable;
    logic        timer_zero;

    // The timer is (re)armed whenever a new select value is about to be driven.
    always_comb begin
        timer_load   = 1'b0;
        timer_enable = 1'b0;
        if (state == ST_IDLE && Start) begin
            timer_load = 1'b1;
        end
        if (state == ST_SAMPLE && Sel != LAST_CH) begin
            timer_load = 1'b1;
        end
        if (state == ST_SETTLE) begin
            timer_enable = 1'b1;
        end
    end

    settle_timer #(
        .W(CNT_W)
    ) u_settle_timer (
        .clk        (Clock),
        .rst_n      (Resetn),
        .load       (timer_load),
        .load_value (RELOAD),
        .enable     (timer_enable),
        .zero       (timer_zero)
    );

    // Scan FSM with select stepping and per-channel capture into Data.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
            Sel   <= '0;
            Data  <= '0;
            Valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        Sel   <= '0;
                        Data  <= '0;
                        state <= AFTER_SEL;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    Data[Sel] <= M_in;
                    if (Sel == LAST_CH) begin
                        Valid <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        Sel   <= Sel + SEL_W'(1);
                        state <= AFTER_SEL;
                    end
                end
                default: begin
                    if (Ready) begin
                        Valid <= 1'b0;
                        Sel   <= '0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef MUX_SCAN_CAPTURE_PARITY_EN
    // Even parity of the full word, written alongside its last bit.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Parity <= 1'b0;
        end else if (state == ST_IDLE && Start) begin
            Parity <= 1'b0;
        end else if (state == ST_SAMPLE && Sel == LAST_CH) begin
            Parity <= M_in ^ (^Data[NUM_CH-2:0]);
        end
    end
`endif

    assign Busy = (state == ST_SETTLE) || (state == ST_SAMPLE);

endmodule

// File: tb/tb_mux_scan_capture.sv
// Testbench for mux_scan_capture: two instances (settle 2 and settle 0)
// fed by an 8:1 mux model, checked against pattern/latency arithmetic.
module tb_mux_scan_capture;
    import mux_scan_pkg::*;

    localparam int NUM_CH = 1 << SEL_W_DEF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;

    logic              start_a, ready_a, valid_a, busy_a, m_in_a;
    logic [2:0]        sel_a;
    logic [NUM_CH-1:0] data_a, pat_a;
    logic              start_b, ready_b, valid_b, busy_b, m_in_b;
    logic [2:0]        sel_b;
    logic [NUM_CH-1:0] data_b, pat_b;
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
    logic              parity_a, parity_b;
`endif

    // 8:1 mux models: the channel pattern indexed by each DUT's select
    assign m_in_a = pat_a[sel_a];
    assign m_in_b = pat_b[sel_b];

    mux_scan_capture #(.SETTLE_CYCLES(2)) dut_a (
        .Clock(clock), .Resetn(resetn), .Start(start_a), .Sel(sel_a),
        .M_in(m_in_a), .Data(data_a), .Valid(valid_a), .Ready(ready_a),
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
        .Parity(parity_a),
`endif
        .Busy(busy_a)
    );

    mux_scan_capture #(.SETTLE_CYCLES(0)) dut_b (
        .Clock(clock), .Resetn(resetn), .Start(start_b), .Sel(sel_b),
        .M_in(m_in_b), .Data(data_b), .Valid(valid_b), .Ready(ready_b),
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
        .Parity(parity_b),
`endif
        .Busy(busy_b)
    );

    int  errors = 0;
    int  checks = 0;
    bit  use_b  = 1'b0;

    logic [2:0]        cur_sel;
    logic [NUM_CH-1:0] cur_data;
    logic              cur_valid, cur_busy;
    assign cur_sel   = use_b ? sel_b   : sel_a;
    assign cur_data  = use_b ? data_b  : data_a;
    assign cur_valid = use_b ? valid_b : valid_a;
    assign cur_busy  = use_b ? busy_b  : busy_a;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_start(input logic v);
        if (use_b) start_b = v; else start_a = v;
    endtask

    task automatic set_ready(input logic v);
        if (use_b) ready_b = v; else ready_a = v;
    endtask

    // Run one full scan of pattern pat; optionally pulse Start when Sel==3.
    task automatic apply_stimulus(input logic [NUM_CH-1:0] pat, input int settle,
                                  input bit poke_mid);
        int lat  = NUM_CH * (settle + 1);
        int rise = -1;
        bit poked = 1'b0;
        int exp_sel;
        if (use_b) pat_b = pat; else pat_a = pat;
        set_start(1'b1);
        @(posedge clock); #1;
        set_start(1'b0);
        check_output("busy_after_start", 32'(cur_busy), 32'd1);
        check_output("data_cleared", 32'(cur_data), 32'd0);
        for (int k = 1; k <= lat + 8; k++) begin
            @(posedge clock); #1;
            if (poked) set_start(1'b0);
            exp_sel = k / (settle + 1);
            if (exp_sel > NUM_CH - 1) exp_sel = NUM_CH - 1;
            if (k <= lat) begin
                check_output("sel_step", 32'(cur_sel), 32'(exp_sel));
                check_output("busy_scan", 32'(cur_busy), (k < lat) ? 32'd1 : 32'd0);
            end
            if (cur_valid) begin
                rise = k;
                break;
            end
            if (poke_mid && !poked && cur_sel == 3'd3) begin
                set_start(1'b1);
                poked = 1'b1;
            end
        end
        set_start(1'b0);
        check_output("valid_latency", 32'(rise), 32'(lat));
        check_output("data_word", 32'(cur_data), 32'(pat));
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
        check_output("parity", use_b ? 32'(parity_b) : 32'(parity_a), 32'(^pat));
`endif
    endtask

    // One-cycle Ready accept, then expect the controller back in idle.
    task automatic accept_word();
        set_ready(1'b1);
        @(posedge clock); #1;
        set_ready(1'b0);
        check_output("accept_valid", 32'(cur_valid), 32'd0);
        check_output("accept_sel", 32'(cur_sel), 32'd0);
        check_output("accept_busy", 32'(cur_busy), 32'd0);
    endtask

    initial begin
        logic [NUM_CH-1:0] hold_pat;
        bit found;
        resetn  = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; pat_a = '0;
        start_b = 1'b0; ready_b = 1'b0; pat_b = '0;
        #12;
        check_output("reset_sel", 32'(sel_a), 32'd0);
        check_output("reset_data", 32'(data_a), 32'd0);
        check_output("reset_valid", 32'(valid_a), 32'd0);
        check_output("reset_busy", 32'(busy_a), 32'd0);
        #10 resetn = 1'b1;
        @(posedge clock); #1;

        // Basic scan, then backpressure with Ready low for 10 cycles
        apply_stimulus(8'hA5, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check_output("bp_valid", 32'(valid_a), 32'd1);
            check_output("bp_data", 32'(data_a), 32'hA5);
            check_output("bp_sel", 32'(sel_a), 32'd7);
        end
        accept_word();

        // Mid-scan Start ignored; Start with Ready in DONE not accepted
        apply_stimulus(8'hA5, 2, 1'b1);
        start_a = 1'b1; ready_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0; ready_a = 1'b0;
        check_output("sr_valid", 32'(valid_a), 32'd0);
        check_output("sr_sel", 32'(sel_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_output("sr_idle_busy", 32'(busy_a), 32'd0);
            check_output("sr_data_kept", 32'(data_a), 32'hA5);
        end
        apply_stimulus(8'h5A, 2, 1'b0);
        accept_word();

        // Asynchronous reset in the middle of a scan
        hold_pat = 8'($urandom);
        pat_a = hold_pat;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (sel_a == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        check_output("reach_sel4", 32'(found), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_output("arst_sel", 32'(sel_a), 32'd0);
        check_output("arst_data", 32'(data_a), 32'd0);
        check_output("arst_valid", 32'(valid_a), 32'd0);
        check_output("arst_busy", 32'(busy_a), 32'd0);
        #2 resetn = 1'b1;
        @(posedge clock); #1;
        check_output("arst_no_valid", 32'(valid_a), 32'd0);
        apply_stimulus(8'h3C, 2, 1'b0);
        accept_word();

        // Random patterns and parity patterns on the settle-2 instance
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(8'($urandom), 2, 1'b0);
            accept_word();
        end
        apply_stimulus(8'h07, 2, 1'b0);
        accept_word();
        apply_stimulus(8'h03, 2, 1'b0);
        accept_word();

        // Zero settle instance
        use_b = 1'b1;
        apply_stimulus(8'hFF, 0, 1'b0);
        accept_word();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(8'($urandom), 0, 1'b0);
            accept_word();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
